// File: rtl/mem_access_unit_pkg.sv
// Shared types for the MEM-stage load/store unit.
// Word / RamAddress size the data path and RAM byte address, MemFunct3 names
// the RV32I load/store funct3 codes. Helpers decode the access size and
// perform load sign/zero extension.
package mem_access_unit_pkg;
  localparam int ADDR_W         = 8;
  localparam int BYTES_PER_WORD = 4;

  typedef logic [31:0]       Word;
  typedef logic [ADDR_W-1:0] RamAddress;

  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LBU = 3'b100,
    LHU = 3'b101
  } MemFunct3;

  // Stores reuse the low three load codes.
  localparam MemFunct3 SB = LB;
  localparam MemFunct3 SH = LH;
  localparam MemFunct3 SW = LW;

  typedef enum logic {IDLE, SECOND} mau_state_t;

  // Access size in bytes from funct3[1:0]; 2'b11 is illegal and caught elsewhere.
  function automatic logic [2:0] size_bytes(input logic [1:0] sz);
    case (sz)
      2'b00:   size_bytes = 3'd1;
      2'b01:   size_bytes = 3'd2;
      default: size_bytes = 3'd4;
    endcase
  endfunction

  // raw holds the loaded bytes right-justified.
  function automatic Word load_extend(input Word raw, input logic [2:0] f3);
    case (f3)
      LB:      load_extend = {{24{raw[7]}}, raw[7:0]};
      LH:      load_extend = {{16{raw[15]}}, raw[15:0]};
      LBU:     load_extend = {24'h0, raw[7:0]};
      LHU:     load_extend = {16'h0, raw[15:0]};
      default: load_extend = raw;
    endcase
  endfunction
endpackage

// File: rtl/mem_access_unit_merge.sv
// byte_lane_merge: replaces lanes first..first+count-1 of i_old with the low
// bytes of i_data (little-endian), leaving the other lanes untouched.
// Ports: i_old (current RAM word), i_data (store bytes, right-justified),
//        i_first (first lane), i_count (lane count 0..4), o_merged.
module byte_lane_merge
  import mem_access_unit_pkg::*;
(
  input  logic [31:0] i_old,
  input  logic [31:0] i_data,
  input  logic [1:0]  i_first,
  input  logic [2:0]  i_count,
  output logic [31:0] o_merged
);
  Word        w_shifted;
  logic [3:0] w_lo;
  logic [3:0] w_hi;

  assign w_shifted = i_data << {i_first, 3'b000};
  assign w_lo      = {2'b00, i_first};
  assign w_hi      = w_lo + {1'b0, i_count};

  for (genvar k = 0; k < BYTES_PER_WORD; k++) begin : g_lane
    logic w_sel;
    assign w_sel = (4'(k) >= w_lo) && (4'(k) < w_hi);
    assign o_merged[8*k +: 8] = w_sel ? w_shifted[8*k +: 8] : i_old[8*k +: 8];
  end
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: RV32I load/store initiator for the MEM stage, driving a
// word-addressed RAM with a combinational read port. Sub-word stores are a
// single-cycle read-modify-write; word-crossing accesses take two cycles
// (or are errors when ALLOW_MISALIGNED=0).
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   i_req_*/o_req_ready   request handshake, op, funct3, byte address, store data
//   o_resp_*              one-cycle response pulse, load data, error flag
//   o_ram_*/i_ram_rdata   RAM write enable, word address, write data, read data
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter bit ALLOW_MISALIGNED = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_write,
  input  logic [2:0]        i_req_funct3,
  input  logic [ADDR_W-1:0] i_req_address,
  input  logic [31:0]       i_req_wdata,
  output logic              o_resp_valid,
  output logic [31:0]       o_resp_rdata,
  output logic              o_resp_error,
  output logic              o_ram_we,
  output logic [ADDR_W-1:0] o_ram_address,
  output logic [31:0]       o_ram_wdata,
  input  logic [31:0]       i_ram_rdata
);
  mau_state_t r_state, w_state_nxt;

  // Latched in cycle A of a crossing access.
  logic       r_write;
  logic [2:0] r_funct3;
  logic [1:0] r_off;
  logic [2:0] r_cnt_b;
  Word        r_wdata_hi;
  Word        r_lo;
  RamAddress  r_w1;

  logic r_resp_valid, r_resp_error;
  Word  r_resp_rdata;

  logic       w_accept, w_legal, w_cross;
  logic [1:0] w_off;
  logic [2:0] w_n;
  logic [3:0] w_end;
  RamAddress  w_base;

  logic       w_we, w_fire, w_err, w_capture;
  Word        w_rdata, w_merged, w_m_data;
  RamAddress  w_addr;
  logic [1:0] w_m_first;
  logic [2:0] w_m_count;

  assign o_req_ready = (r_state == IDLE) && !reset;
  assign w_accept    = i_req_valid && o_req_ready;
  assign w_off       = i_req_address[1:0];
  assign w_n         = size_bytes(i_req_funct3[1:0]);
  assign w_end       = {2'b00, w_off} + {1'b0, w_n};
  assign w_cross     = w_end > 4'd4;
  assign w_base      = {i_req_address[ADDR_W-1:2], 2'b00};

  // Stores: 000/001/010 only. Loads additionally allow 100/101.
  assign w_legal = (i_req_funct3[1:0] != 2'b11) &&
                   (i_req_write ? !i_req_funct3[2] : !(i_req_funct3[2] && i_req_funct3[1]));

  byte_lane_merge u_merge (
    .i_old    (i_ram_rdata),
    .i_data   (w_m_data),
    .i_first  (w_m_first),
    .i_count  (w_m_count),
    .o_merged (w_merged)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_we        = 1'b0;
    w_addr      = w_base;
    w_m_first   = w_off;
    w_m_count   = w_n;
    w_m_data    = i_req_wdata;
    w_fire      = 1'b0;
    w_err       = 1'b0;
    w_rdata     = '0;
    w_capture   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (!w_legal || (w_cross && !ALLOW_MISALIGNED)) begin
            w_fire = 1'b1;
            w_err  = 1'b1;
          end else if (w_cross) begin
            // Cycle A: lanes off..3 of the low word.
            w_we        = i_req_write;
            w_m_count   = 3'd4 - {1'b0, w_off};
            w_capture   = 1'b1;
            w_state_nxt = SECOND;
          end else begin
            w_we    = i_req_write;
            w_fire  = 1'b1;
            w_rdata = i_req_write ? '0 :
                      load_extend(i_ram_rdata >> {w_off, 3'b000}, i_req_funct3);
          end
        end
      end
      SECOND: begin
        // Cycle B: lanes 0..r_cnt_b-1 of the next word.
        w_addr      = r_w1;
        w_m_first   = 2'd0;
        w_m_count   = r_cnt_b;
        w_m_data    = r_wdata_hi;
        w_we        = r_write;
        w_fire      = 1'b1;
        w_rdata     = r_write ? '0 :
                      load_extend(r_lo | (i_ram_rdata << (6'd32 - {1'b0, r_off, 3'b000})),
                                  r_funct3);
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_error <= 1'b0;
    end else begin
      r_resp_valid <= w_fire;
      if (w_fire) begin
        r_resp_rdata <= w_rdata;
        r_resp_error <= w_err;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_capture) begin
      r_write    <= i_req_write;
      r_funct3   <= i_req_funct3;
      r_off      <= w_off;
      r_cnt_b    <= 3'(w_end - 4'd4);
      // Store bytes not consumed in cycle A, right-justified for cycle B.
      r_wdata_hi <= i_req_wdata >> (6'd32 - {1'b0, w_off, 3'b000});
      r_lo       <= i_ram_rdata >> {w_off, 3'b000};
      // Wraps naturally at the top of the address range.
      r_w1       <= w_base + RamAddress'(BYTES_PER_WORD);
    end
  end

  assign o_ram_we      = w_we && !reset;
  assign o_ram_address = w_addr;
  assign o_ram_wdata   = o_ram_we ? w_merged : '0;
  assign o_resp_valid  = r_resp_valid;
  assign o_resp_rdata  = r_resp_rdata;
  assign o_resp_error  = r_resp_error;
endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, mem_clr;
  logic        req_valid, req_ready, req_write;
  logic [2:0]  req_funct3;
  logic [7:0]  req_address;
  logic [31:0] req_wdata;
  logic        resp_valid, resp_error;
  logic [31:0] resp_rdata;
  logic        ram_we;
  logic [7:0]  ram_address;
  logic [31:0] ram_wdata, ram_rdata;

  logic        na_valid, na_ready, na_write;
  logic [2:0]  na_funct3;
  logic [7:0]  na_address;
  logic [31:0] na_wdata;
  logic        na_resp_valid, na_resp_error;
  logic [31:0] na_resp_rdata;
  logic        na_we;
  logic [7:0]  na_ram_address;
  logic [31:0] na_ram_wdata, na_ram_rdata;

  mem_access_unit #(.ALLOW_MISALIGNED(1'b1)) dut (
    .clk(clk), .reset(reset),
    .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_write(req_write),
    .i_req_funct3(req_funct3), .i_req_address(req_address), .i_req_wdata(req_wdata),
    .o_resp_valid(resp_valid), .o_resp_rdata(resp_rdata), .o_resp_error(resp_error),
    .o_ram_we(ram_we), .o_ram_address(ram_address), .o_ram_wdata(ram_wdata),
    .i_ram_rdata(ram_rdata)
  );

  mem_access_unit #(.ALLOW_MISALIGNED(1'b0)) dut_na (
    .clk(clk), .reset(reset),
    .i_req_valid(na_valid), .o_req_ready(na_ready), .i_req_write(na_write),
    .i_req_funct3(na_funct3), .i_req_address(na_address), .i_req_wdata(na_wdata),
    .o_resp_valid(na_resp_valid), .o_resp_rdata(na_resp_rdata), .o_resp_error(na_resp_error),
    .o_ram_we(na_we), .o_ram_address(na_ram_address), .o_ram_wdata(na_ram_wdata),
    .i_ram_rdata(na_ram_rdata)
  );

  // RAM models: combinational read, write on the clock edge.
  logic [31:0] mem    [64];
  logic [31:0] mem_na [64];
  int we_cnt = 0;
  int na_we_cnt = 0;
  assign ram_rdata    = mem[ram_address[7:2]];
  assign na_ram_rdata = mem_na[na_ram_address[7:2]];

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 64; i++) begin
        mem[i]    <= 32'h0;
        mem_na[i] <= 32'hA5A5_0000 | i;
      end
    end else begin
      if (ram_we) begin
        mem[ram_address[7:2]] <= ram_wdata;
        we_cnt <= we_cnt + 1;
      end
      if (na_we) begin
        mem_na[na_ram_address[7:2]] <= na_ram_wdata;
        na_we_cnt <= na_we_cnt + 1;
      end
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  typedef struct {
    string       tag;
    logic [31:0] rdata;
    logic        err;
  } exp_t;
  exp_t sb[$];

  always @(negedge clk) begin
    exp_t e;
    if (resp_valid) begin
      if (sb.size() == 0) chk("unexpected_resp", 32'd1, 32'd0);
      else begin
        e = sb.pop_front();
        chk({e.tag, "_rdata"}, resp_rdata, e.rdata);
        chk({e.tag, "_err"}, {31'd0, resp_error}, {31'd0, e.err});
      end
    end
  end

  // Called just after a falling edge; returns at the falling edge after acceptance.
  task automatic send(input string tag, input logic w, input logic [2:0] f3,
                      input logic [7:0] a, input logic [31:0] d,
                      input bit has_resp, input logic [31:0] er, input logic ee);
    int t = 0;
    while (!req_ready && t < 20) begin @(negedge clk); t++; end
    if (!req_ready) chk({tag, "_ready_timeout"}, 32'd0, 32'd1);
    req_valid = 1'b1; req_write = w; req_funct3 = f3; req_address = a; req_wdata = d;
    if (has_resp) sb.push_back('{tag, er, ee});
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 50) begin @(negedge clk); t++; end
    if (sb.size() != 0) begin
      chk("drain_timeout", sb.size(), 32'd0);
      sb.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  int w0;

  initial begin
    reset = 1'b1; mem_clr = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'b0; req_address = 8'h0; req_wdata = 32'h0;
    na_valid = 1'b0; na_write = 1'b0; na_funct3 = 3'b0; na_address = 8'h0; na_wdata = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    chk("rst_err", {31'd0, resp_error}, 32'd0);
    chk("rst_we", {31'd0, ram_we}, 32'd0);
    reset = 1'b0; mem_clr = 1'b0;
    #1 chk("post_rst_ready", {31'd0, req_ready}, 32'd1);

    // Aligned word store/load.
    w0 = we_cnt;
    send("sw10", 1'b1, SW, 8'h10, 32'hDEADBEEF, 1, 32'h0, 1'b0);
    send("lw10", 1'b0, LW, 8'h10, 32'h0, 1, 32'hDEADBEEF, 1'b0);
    drain();
    chk("sw10_we_cycles", we_cnt - w0, 32'd1);

    // Sub-word read-modify-write and extension.
    send("sb11", 1'b1, SB, 8'h11, 32'hFFFFFF80, 1, 32'h0, 1'b0);
    send("lb11", 1'b0, LB, 8'h11, 32'h0, 1, 32'hFFFFFF80, 1'b0);
    send("lbu11", 1'b0, LBU, 8'h11, 32'h0, 1, 32'h00000080, 1'b0);
    send("lh12", 1'b0, LH, 8'h12, 32'h0, 1, 32'hFFFFDEAD, 1'b0);
    send("lhu12", 1'b0, LHU, 8'h12, 32'h0, 1, 32'h0000DEAD, 1'b0);
    drain();
    chk("mem10_sb", mem[4], 32'hDEAD80EF);
    send("sh12", 1'b1, SH, 8'h12, 32'hAAAA1234, 1, 32'h0, 1'b0);
    drain();
    chk("mem10_sh", mem[4], 32'h123480EF);

    // Crossing store: stall for exactly one cycle.
    w0 = we_cnt;
    send("sw23", 1'b1, SW, 8'h23, 32'h11223344, 1, 32'h0, 1'b0);
    chk("sw23_stall", {31'd0, req_ready}, 32'd0);
    @(negedge clk);
    chk("sw23_ready_back", {31'd0, req_ready}, 32'd1);
    drain();
    chk("sw23_we_cycles", we_cnt - w0, 32'd2);
    chk("mem20_cross", mem[8], 32'h44000000);
    chk("mem24_cross", mem[9], 32'h00112233);
    send("lw23", 1'b0, LW, 8'h23, 32'h0, 1, 32'h11223344, 1'b0);
    send("lh23", 1'b0, LH, 8'h23, 32'h0, 1, 32'h00003344, 1'b0);
    send("lhu23", 1'b0, LHU, 8'h23, 32'h0, 1, 32'h00003344, 1'b0);
    drain();

    // Illegal funct3.
    w0 = we_cnt;
    send("ld011", 1'b0, 3'b011, 8'h10, 32'h0, 1, 32'h0, 1'b1);
    send("st100", 1'b1, 3'b100, 8'h10, 32'hFFFFFFFF, 1, 32'h0, 1'b1);
    send("st101", 1'b1, 3'b101, 8'h10, 32'hFFFFFFFF, 1, 32'h0, 1'b1);
    drain();
    chk("illegal_we_cycles", we_cnt - w0, 32'd0);
    chk("illegal_mem10", mem[4], 32'h123480EF);

    // Reset while in SECOND: cycle-A write kept, cycle-B write dropped.
    send("sw20", 1'b1, SW, 8'h20, 32'h0, 1, 32'h0, 1'b0);
    send("sw24", 1'b1, SW, 8'h24, 32'hCAFEF00D, 1, 32'h0, 1'b0);
    drain();
    send("sw23_rst", 1'b1, SW, 8'h23, 32'h11223344, 0, 32'h0, 1'b0);
    reset = 1'b1;
    #1 chk("rst_second_we", {31'd0, ram_we}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1 chk("rst_second_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_second_mem20", mem[8], 32'h44000000);
    chk("rst_second_mem24", mem[9], 32'hCAFEF00D);
    @(negedge clk);

    // Top-word wrap: second word is word 0.
    send("swfc", 1'b1, SW, 8'hFC, 32'hAABBCCDD, 1, 32'h0, 1'b0);
    send("sw00", 1'b1, SW, 8'h00, 32'h11223344, 1, 32'h0, 1'b0);
    send("lwfe", 1'b0, LW, 8'hFE, 32'h0, 1, 32'h3344AABB, 1'b0);
    chk("wrap_addr", {24'd0, ram_address}, 32'd0);
    drain();

    // ALLOW_MISALIGNED=0 instance: crossing halfword store is an error.
    na_valid = 1'b1; na_write = 1'b1; na_funct3 = SH; na_address = 8'h1F; na_wdata = 32'h0000BEEF;
    #1 chk("na_sh1f_we", {31'd0, na_we}, 32'd0);
    @(negedge clk);
    na_valid = 1'b1; na_write = 1'b0; na_funct3 = LW; na_address = 8'h20;
    chk("na_sh1f_valid", {31'd0, na_resp_valid}, 32'd1);
    chk("na_sh1f_err", {31'd0, na_resp_error}, 32'd1);
    chk("na_sh1f_rdata", na_resp_rdata, 32'd0);
    chk("na_ready", {31'd0, na_ready}, 32'd1);
    @(negedge clk);
    na_valid = 1'b0;
    chk("na_lw20_valid", {31'd0, na_resp_valid}, 32'd1);
    chk("na_lw20_err", {31'd0, na_resp_error}, 32'd0);
    chk("na_lw20_rdata", na_resp_rdata, 32'hA5A50008);
    chk("na_mem1c", mem_na[7], 32'hA5A50007);
    chk("na_mem20", mem_na[8], 32'hA5A50008);
    chk("na_we_cycles", na_we_cnt, 32'd0);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
